// File: rtl/keypad_pkg.sv
// Shared types for the keypad entry block.
package keypad_pkg;

    localparam int unsigned KEY_W = 4;

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} kp_state_t;
    typedef logic [KEY_W-1:0] key_code_t;

endpackage

// File: rtl/keypad_debounce.sv
// Synchronises the scanner key stream, debounces press/release and reports one event per press.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic      clk,
    input  logic      rst,
    input  key_code_t key_value,
    input  logic      key_valid,
    output logic      accept_c,
    output key_code_t cand_c,
    output logic      press_strobe,
    output key_code_t press_code
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             valid_meta_q, vs_q;
    key_code_t        code_meta_q, cs_q;
    kp_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    key_code_t        cand_q, cand_d;
    logic             strobe_q, strobe_d;
    key_code_t        code_q, code_d;

    // Two-flop synchronisers, FSM state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_meta_q <= 1'b0;
            vs_q         <= 1'b0;
            code_meta_q  <= '0;
            cs_q         <= '0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            cand_q       <= '0;
            strobe_q     <= 1'b0;
            code_q       <= '0;
        end else begin
            valid_meta_q <= key_valid;
            vs_q         <= valid_meta_q;
            code_meta_q  <= key_value;
            cs_q         <= code_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cand_q       <= cand_d;
            strobe_q     <= strobe_d;
            code_q       <= code_d;
        end
    end

    // Next-state logic; the counter restarts on every state entry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        accept_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (vs_q) begin
                    state_d = PRESS_DB;
                    cand_d  = cs_q;
                    cnt_d   = '0;
                end
            end
            PRESS_DB: begin
                if (!vs_q || (cs_q != cand_q)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = HELD;
                    cnt_d    = '0;
                    accept_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!vs_q) begin
                    state_d = RELEASE_DB;
                    cnt_d   = '0;
                end
            end
            RELEASE_DB: begin
                if (vs_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        strobe_d = accept_c;
        code_d   = accept_c ? cand_q : code_q;
    end

    assign cand_c       = cand_q;
    assign press_strobe = strobe_q;
    assign press_code   = code_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry: debounced key presses shifted into a multi-digit entry register.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DIGITS          = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [KEY_W-1:0]               key_value,
    input  logic                           key_valid,
    input  logic                           clear,
    output logic                           key_strobe,
    output logic [KEY_W-1:0]               key_code,
    output logic [KEY_W*DIGITS-1:0]        digits,
    output logic [$clog2(DIGITS+1)-1:0]    digit_count,
    output logic                           entry_full
);

    localparam int unsigned DW    = KEY_W * DIGITS;
    localparam int unsigned CW    = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CMAX = CW'(DIGITS);

    logic          accept_c;
    key_code_t     cand_c;
    logic [DW-1:0] shifted_c;
    logic [DW-1:0] digits_q, digits_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;

    keypad_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .key_value   (key_value),
        .key_valid   (key_valid),
        .accept_c    (accept_c),
        .cand_c      (cand_c),
        .press_strobe(key_strobe),
        .press_code  (key_code)
    );

    generate
        if (DIGITS == 1) begin : g_single
            assign shifted_c = cand_c;
        end else begin : g_shift
            assign shifted_c = {digits_q[DW-KEY_W-1:0], cand_c};
        end
    endgenerate

    // Clear takes priority over a press accepted on the same edge.
    always_comb begin
        digits_d = digits_q;
        count_d  = count_q;
        if (clear) begin
            digits_d = '0;
            count_d  = '0;
        end else if (accept_c) begin
            digits_d = shifted_c;
            count_d  = (count_q == CMAX) ? count_q : count_q + CW'(1);
        end
        full_d = (count_d == CMAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            digits_q <= digits_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    assign digits      = digits_q;
    assign digit_count = count_q;
    assign entry_full  = full_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed scenarios plus randomized key traffic against a reference model.
module tb_keypad_entry;

    localparam int DC     = 4;
    localparam int DIGITS = 4;
    localparam int DW     = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    key_value;
    logic          key_valid;
    logic          clear;
    logic          key_strobe;
    logic [3:0]    key_code;
    logic [DW-1:0] digits;
    logic [2:0]    digit_count;
    logic          entry_full;

    int vectors = 0;
    int errors  = 0;

    keypad_entry #(.DEBOUNCE_CYCLES(DC), .DIGITS(DIGITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_value  (key_value),
        .key_valid  (key_valid),
        .clear      (clear),
        .key_strobe (key_strobe),
        .key_code   (key_code),
        .digits     (digits),
        .digit_count(digit_count),
        .entry_full (entry_full)
    );

    always #5 clk = ~clk;

    // Reference model: a key is accepted after DC+1 consecutive synced samples
    // that are down with the same code; it is released after DC+1 consecutive
    // up samples. A code change aborts a press and the next sample starts fresh.
    logic       m_v1, m_v2;
    logic [3:0] m_c1, m_c2;
    bit         m_waiting;
    int         m_run, m_zero;
    logic [3:0] m_cand;
    logic       m_strobe;
    logic [3:0] m_code;
    int         m_q[$];

    task automatic model_edge(input logic v, input logic [3:0] val, input logic clr, input logic r);
        logic       vs;
        logic [3:0] cs;
        bit         accept;
        m_strobe = 1'b0;
        if (r) begin
            m_v1 = 0; m_v2 = 0; m_c1 = 0; m_c2 = 0;
            m_waiting = 1; m_run = 0; m_zero = 0; m_cand = 0;
            m_code = 0;
            m_q.delete();
            return;
        end
        vs = m_v2; cs = m_c2;
        m_v2 = m_v1; m_c2 = m_c1;
        m_v1 = v;    m_c1 = val;
        accept = 0;
        if (m_waiting) begin
            if (m_run == 0) begin
                if (vs) begin
                    m_run = 1;
                    m_cand = cs;
                end
            end else if (!vs || cs != m_cand) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == DC + 1) begin
                    accept = 1; m_waiting = 0; m_run = 0; m_zero = 0;
                end
            end
        end else if (vs) begin
            m_zero = 0;
        end else begin
            m_zero++;
            if (m_zero == DC + 1) begin
                m_waiting = 1; m_zero = 0;
            end
        end
        if (accept) begin
            m_strobe = 1'b1;
            m_code = m_cand;
        end
        if (clr) m_q.delete();
        else if (accept) begin
            m_q.push_front(int'(m_cand));
            if (m_q.size() > DIGITS) void'(m_q.pop_back());
        end
    endtask

    function automatic logic [DW-1:0] model_digits();
        logic [DW-1:0] d = '0;
        for (int i = 0; i < m_q.size(); i++) d[4*i +: 4] = 4'(m_q[i]);
        return d;
    endfunction

    task automatic step(input logic v, input logic [3:0] val, input logic clr, input logic r);
        key_valid = v; key_value = val; clear = clr; rst = r;
        @(posedge clk);
        model_edge(v, val, clr, r);
        #1;
    endtask

    // Applies a constant input for len cycles, tracking strobes and the index of the last one.
    task automatic run_phase(input logic v, input logic [3:0] val, input int len, input int base,
                             inout int n, inout int idx);
        for (int i = 0; i < len; i++) begin
            step(v, val, 1'b0, 1'b0);
            if (key_strobe) begin
                n++;
                idx = base + i;
            end
        end
    endtask

    task automatic test_reset();
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        vectors++; if (key_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", key_strobe); end
        vectors++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code got %h want 0", key_code); end
        vectors++; if (digits !== 16'h0) begin errors++; $display("FAIL reset_digits got %h want 0", digits); end
        vectors++; if (digit_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", digit_count); end
        vectors++; if (entry_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", entry_full); end
    endtask

    task automatic test_clean_press();
        int n = 0, idx = -1;
        run_phase(1'b1, 4'h5, 20, 0, n, idx);
        run_phase(1'b0, 4'h5, 20, 20, n, idx);
        vectors++; if (n !== 1) begin errors++; $display("FAIL clean_strobes got %0d want 1", n); end
        vectors++; if (idx !== DC + 2) begin errors++; $display("FAIL clean_latency got %0d want %0d", idx, DC + 2); end
        vectors++; if (key_code !== 4'h5) begin errors++; $display("FAIL clean_code got %h want 5", key_code); end
        vectors++; if (digits !== 16'h0005) begin errors++; $display("FAIL clean_digits got %h want 0005", digits); end
        vectors++; if (digit_count !== 3'd1) begin errors++; $display("FAIL clean_count got %0d want 1", digit_count); end
    endtask

    task automatic test_press_bounce();
        int n = 0, idx = -1;
        run_phase(1'b1, 4'h9, 1, 0, n, idx);
        run_phase(1'b0, 4'h9, 1, 1, n, idx);
        run_phase(1'b1, 4'h9, 1, 2, n, idx);
        run_phase(1'b0, 4'h9, 1, 3, n, idx);
        run_phase(1'b1, 4'h9, 20, 4, n, idx);
        run_phase(1'b0, 4'h9, 20, 24, n, idx);
        vectors++; if (n !== 1) begin errors++; $display("FAIL bounce_strobes got %0d want 1", n); end
        vectors++; if (idx !== 4 + DC + 2) begin errors++; $display("FAIL bounce_latency got %0d want %0d", idx, 4 + DC + 2); end
        vectors++; if (key_code !== 4'h9) begin errors++; $display("FAIL bounce_code got %h want 9", key_code); end
        vectors++; if (digits !== 16'h0059) begin errors++; $display("FAIL bounce_digits got %h want 0059", digits); end
    endtask

    task automatic test_release_rollover();
        int n = 0, idx = -1;
        run_phase(1'b1, 4'h3, 12, 0, n, idx);
        run_phase(1'b0, 4'h3, 2, 12, n, idx);
        run_phase(1'b1, 4'h7, 12, 14, n, idx);
        run_phase(1'b0, 4'h7, 20, 26, n, idx);
        vectors++; if (n !== 1) begin errors++; $display("FAIL rollover_strobes got %0d want 1", n); end
        vectors++; if (key_code !== 4'h3) begin errors++; $display("FAIL rollover_code got %h want 3", key_code); end
        vectors++; if (digit_count !== 3'd3) begin errors++; $display("FAIL rollover_count got %0d want 3", digit_count); end
    endtask

    task automatic test_overflow();
        int n = 0, idx = -1;
        step(1'b0, 4'h0, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            run_phase(1'b1, 4'(k), 12, 0, n, idx);
            run_phase(1'b0, 4'(k), 12, 0, n, idx);
            if (k == 4) begin
                vectors++; if (digits !== 16'h1234) begin errors++; $display("FAIL ovf4_digits got %h want 1234", digits); end
                vectors++; if (entry_full !== 1'b1) begin errors++; $display("FAIL ovf4_full got %b want 1", entry_full); end
            end
        end
        vectors++; if (digits !== 16'h2345) begin errors++; $display("FAIL ovf5_digits got %h want 2345", digits); end
        vectors++; if (digit_count !== 3'd4) begin errors++; $display("FAIL ovf5_count got %0d want 4", digit_count); end
        vectors++; if (entry_full !== 1'b1) begin errors++; $display("FAIL ovf5_full got %b want 1", entry_full); end
    endtask

    task automatic test_clear_collision();
        int n = 0, idx = -1;
        run_phase(1'b1, 4'hA, DC + 2, 0, n, idx);
        step(1'b1, 4'hA, 1'b1, 1'b0);
        vectors++; if (key_strobe !== 1'b1) begin errors++; $display("FAIL clr_strobe got %b want 1", key_strobe); end
        vectors++; if (key_code !== 4'hA) begin errors++; $display("FAIL clr_code got %h want a", key_code); end
        vectors++; if (digits !== 16'h0) begin errors++; $display("FAIL clr_digits got %h want 0", digits); end
        vectors++; if (digit_count !== 3'd0) begin errors++; $display("FAIL clr_count got %0d want 0", digit_count); end
        vectors++; if (entry_full !== 1'b0) begin errors++; $display("FAIL clr_full got %b want 0", entry_full); end
        run_phase(1'b1, 4'hA, 4, 0, n, idx);
        run_phase(1'b0, 4'hA, 20, 0, n, idx);
    endtask

    task automatic test_reset_mid_hold();
        int n = 0, idx = -1;
        run_phase(1'b1, 4'h6, 10, 0, n, idx);
        step(1'b1, 4'h6, 1'b0, 1'b1);
        vectors++; if (key_code !== 4'h0) begin errors++; $display("FAIL rsthold_code got %h want 0", key_code); end
        vectors++; if (digits !== 16'h0) begin errors++; $display("FAIL rsthold_digits got %h want 0", digits); end
        vectors++; if (digit_count !== 3'd0) begin errors++; $display("FAIL rsthold_count got %0d want 0", digit_count); end
        n = 0; idx = -1;
        run_phase(1'b1, 4'h6, 20, 0, n, idx);
        run_phase(1'b0, 4'h6, 20, 20, n, idx);
        vectors++; if (n !== 1) begin errors++; $display("FAIL rsthold_strobes got %0d want 1", n); end
        vectors++; if (idx !== DC + 2) begin errors++; $display("FAIL rsthold_latency got %0d want %0d", idx, DC + 2); end
        vectors++; if (digit_count !== 3'd1) begin errors++; $display("FAIL rsthold_count2 got %0d want 1", digit_count); end
    endtask

    task automatic test_random();
        logic       intent = 1'b0;
        logic [3:0] code   = 4'h0;
        int         left   = 0;
        logic       v, clr, r;
        step(1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4000; i++) begin
            if (left == 0) begin
                intent = ~intent;
                left   = int'($urandom_range(3, 20));
                code   = 4'($urandom_range(0, 15));
            end
            left--;
            v = intent;
            if ($urandom_range(0, 7) == 0) v = ~v;
            if (intent && $urandom_range(0, 15) == 0) code = 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 39) == 0);
            r   = ($urandom_range(0, 499) == 0);
            step(v, code, clr, r);
            vectors++; if (key_strobe !== m_strobe) begin errors++; $display("FAIL rnd_strobe cyc %0d got %b want %b", i, key_strobe, m_strobe); end
            vectors++; if (key_code !== m_code) begin errors++; $display("FAIL rnd_code cyc %0d got %h want %h", i, key_code, m_code); end
            vectors++; if (digits !== model_digits()) begin errors++; $display("FAIL rnd_digits cyc %0d got %h want %h", i, digits, model_digits()); end
            vectors++; if (digit_count !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, digit_count, m_q.size()); end
            vectors++; if (entry_full !== (m_q.size() == DIGITS)) begin errors++; $display("FAIL rnd_full cyc %0d got %b want %b", i, entry_full, m_q.size() == DIGITS); end
        end
    endtask

    initial begin
        rst = 1'b1; key_value = 4'h0; key_valid = 1'b0; clear = 1'b0;
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_rollover();
        test_overflow();
        test_clear_collision();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
